// File: rtl/exp_update_pipe_pkg.sv
// Shared definitions for the exponent-update pipeline.
// Holds the internal exponent width rule, EMAX/bias helpers and the
// result-class encoding that orders the stage-2 priority decisions.
package exp_update_pipe_pkg;

  // Two guard bits above the exponent field: one for the +2 carry headroom,
  // one for the sign, so the internal exponent never wraps.
  localparam int IE_GUARD = 2;

  function automatic int ie_width(input int exp_w);
    return exp_w + IE_GUARD;
  endfunction

  function automatic int emax_of(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Result classes, listed in decreasing priority.
  typedef enum logic [2:0] {
    CLS_CANCEL = 3'd0,
    CLS_SAT    = 3'd1,
    CLS_UNDER  = 3'd2,
    CLS_DENORM = 3'd3,
    CLS_NORMAL = 3'd4
  } exp_class_e;

endpackage

// File: rtl/exp_update_pipe_if.sv
// Bundle of the exponent-update pipeline's data/handshake signals.
// master: producer of operands and consumer of results (the datapath around
// the block); slave: the exponent-update pipeline itself.
interface exp_update_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24,
  parameter int SUM_W = 27,
  parameter int LZC_W = 5
);

  logic             en;
  logic             in_valid;
  logic [EXP_W-1:0] exp_in;
  logic             ovf;
  logic             ovf_rnd;
  logic [LZC_W-1:0] lzc;
  logic             one_shift_left;
  logic [SUM_W-1:0] sum;
  logic [MAN_W-1:0] mant_in;
  logic             eop_in;
  logic             zero_d_in;
  logic             ftz;

  logic             out_valid;
  logic [EXP_W-1:0] exp_out;
  logic             max_exp_z;
  logic             min_exp_z;
  logic [EXP_W+1:0] exc_shift;
  logic             underflow_flag;

  modport master (
    output en, in_valid, exp_in, ovf, ovf_rnd, lzc, one_shift_left,
           sum, mant_in, eop_in, zero_d_in, ftz,
    input  out_valid, exp_out, max_exp_z, min_exp_z, exc_shift, underflow_flag
  );

  modport slave (
    input  en, in_valid, exp_in, ovf, ovf_rnd, lzc, one_shift_left,
           sum, mant_in, eop_in, zero_d_in, ftz,
    output out_valid, exp_out, max_exp_z, min_exp_z, exc_shift, underflow_flag
  );

endinterface

// File: rtl/exp_update_pipe_sb_delay_line.sv
// Enabled W x DEPTH shift register for early-arriving side-band flags.
// Ports: clk, rst (async active-low), en (advance), din in, dout = last stage.
// Latency DEPTH en-cycles; en=0 freezes every stage.
module sb_delay_line #(
  parameter int W     = 2,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (en) begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/exp_update_pipe.sv
// Two-stage exponent update: internal exponent, then saturate/underflow/denormal.
// Ports: clk, rst (async active-low), bus (slave side of exp_update_pipe_if).
// Latency 2 en-cycles; en=0 holds all state, side-band chain included.
module exp_update_pipe
  import exp_update_pipe_pkg::*;
#(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 24,
  parameter int SUM_W    = 27,
  parameter int LZC_W    = 5,
  parameter int SB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  exp_update_pipe_if.slave  bus
);

  localparam int IE_W = ie_width(EXP_W);
  localparam logic signed [IE_W-1:0] EMAX_IE = IE_W'(emax_of(EXP_W));
  localparam logic signed [IE_W-1:0] IE_ONE  = IE_W'(1);
  localparam logic [EXP_W-1:0]       EMAX_EXP = EXP_W'(emax_of(EXP_W));

  // ---------------- Stage 1: internal exponent ----------------
  // All operands are zero-extended into IE_W bits; two's-complement wrap in
  // IE_W bits is exactly the signed result, since the range fits.
  logic [IE_W-1:0] ie_sum;
  assign ie_sum = IE_W'(bus.exp_in) + IE_W'(bus.ovf) + IE_W'(bus.ovf_rnd)
                - IE_W'(bus.lzc) - IE_W'(bus.one_shift_left);

  logic signed [IE_W-1:0] ie_q;
  logic [SUM_W-1:0]       sum_q;
  logic [MAN_W-1:0]       mant_q;
  logic                   vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q   <= '0;
      sum_q  <= '0;
      mant_q <= '0;
      vld_q  <= 1'b0;
    end else if (bus.en) begin
      ie_q   <= signed'(ie_sum);
      sum_q  <= bus.sum;
      mant_q <= bus.mant_in;
      vld_q  <= bus.in_valid;
    end
  end

  // Only the hidden bit of the mantissa affects the exponent decision.
  logic unused_mant_bits;
  assign unused_mant_bits = ^mant_q[MAN_W-2:0];

  // ---------------- Side-band alignment ----------------
  // Flags arrive SB_DEPTH-1 en-cycles ahead of their main-path data; the last
  // chain stage lines up with the stage-1 registers of the same transaction.
  logic [1:0] sb_d;
  logic       eop_d;
  logic       zero_d_d;

  sb_delay_line #(
    .W     (2),
    .DEPTH (SB_DEPTH)
  ) u_sb_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .din  ({bus.eop_in, bus.zero_d_in}),
    .dout (sb_d)
  );

  assign eop_d    = sb_d[1];
  assign zero_d_d = sb_d[0];

  // ---------------- Stage 2: classification ----------------
  exp_class_e cls;

  always_comb begin
    cls = CLS_NORMAL;
    if (zero_d_d || (eop_d && (sum_q == '0))) begin
      cls = CLS_CANCEL;          // exact cancellation wins over everything
    end else if (ie_q >= EMAX_IE) begin
      cls = CLS_SAT;
    end else if (ie_q < IE_ONE) begin
      cls = CLS_UNDER;
    end else if ((ie_q == IE_ONE) && !mant_q[MAN_W-1]) begin
      cls = CLS_DENORM;          // exponent 1 without hidden bit is a denormal
    end
  end

  logic [EXP_W-1:0] exp_n;
  logic             max_n;
  logic             min_n;
  logic             uf_n;
  logic [IE_W-1:0]  sh_n;

  always_comb begin
    exp_n = '0;
    max_n = 1'b0;
    min_n = 1'b0;
    uf_n  = 1'b0;
    sh_n  = '0;
    case (cls)
      CLS_CANCEL: begin
        min_n = 1'b1;
      end
      CLS_SAT: begin
        exp_n = EMAX_EXP;
        max_n = 1'b1;
      end
      CLS_UNDER: begin
        min_n = 1'b1;
        uf_n  = 1'b1;
        // Right shift needed to bring the exponent up to the denormal scale.
        sh_n  = bus.ftz ? '0 : IE_W'(IE_ONE - ie_q);
      end
      CLS_DENORM: begin
        min_n = 1'b1;
      end
      default: begin
        exp_n = ie_q[EXP_W-1:0];
      end
    endcase
  end

  logic [EXP_W-1:0] exp_q;
  logic             max_q;
  logic             min_q;
  logic             uf_q;
  logic [IE_W-1:0]  sh_q;
  logic             out_vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q     <= '0;
      max_q     <= 1'b0;
      min_q     <= 1'b0;
      uf_q      <= 1'b0;
      sh_q      <= '0;
      out_vld_q <= 1'b0;
    end else if (bus.en) begin
      // Outputs follow stage 1 every enabled cycle, valid or not.
      exp_q     <= exp_n;
      max_q     <= max_n;
      min_q     <= min_n;
      uf_q      <= uf_n;
      sh_q      <= sh_n;
      out_vld_q <= vld_q;
    end
  end

  assign bus.out_valid      = out_vld_q;
  assign bus.exp_out        = exp_q;
  assign bus.max_exp_z      = max_q;
  assign bus.min_exp_z      = min_q;
  assign bus.underflow_flag = uf_q;
  assign bus.exc_shift      = sh_q;

endmodule
